// File: rtl/operand_fetch.sv
// Issue stage between decode and execute: scoreboard hazard stall, register file
// read requests on two channels, same-cycle writeback forwarding, valid/ready to execute.
module operand_fetch #(
    parameter int XLEN = 32,
    parameter int XCNT = 32,
    parameter int PW   = 32,
    localparam int AW  = $clog2(XCNT)
) (
    input  logic            CLK,
    input  logic            RSTN,
    input  logic            ID_VALID,
    output logic            ID_READY,
    input  logic [AW-1:0]   ID_RS1,
    input  logic [AW-1:0]   ID_RS2,
    input  logic [AW-1:0]   ID_RD,
    input  logic            ID_USE_RS1,
    input  logic            ID_USE_RS2,
    input  logic            ID_WRITES_RD,
    input  logic [PW-1:0]   ID_PAYLOAD,
    output logic [AW-1:0]   RCH1_IDX,
    output logic [AW-1:0]   RCH2_IDX,
    output logic            RCH1_REQ,
    output logic            RCH2_REQ,
    input  logic [XLEN-1:0] RCH1_VAL,
    input  logic [XLEN-1:0] RCH2_VAL,
    input  logic            WB_VALID,
    input  logic [AW-1:0]   WB_IDX,
    input  logic [XLEN-1:0] WB_VAL,
    output logic            EX_VALID,
    input  logic            EX_READY,
    output logic [XLEN-1:0] EX_OP1,
    output logic [XLEN-1:0] EX_OP2,
    output logic [AW-1:0]   EX_RD,
    output logic            EX_WRITES_RD,
    output logic [PW-1:0]   EX_PAYLOAD,
    output logic [XCNT-1:0] SB_BUSY
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_STALL = 2'd1;
    localparam logic [1:0] S_READ  = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    localparam logic [XCNT-1:0] ONE_HOT0 = {{(XCNT-1){1'b0}}, 1'b1};

    logic [1:0]      state;
    logic [AW-1:0]   rs1_q, rs2_q, rd_q;
    logic            use_rs1_q, use_rs2_q, writes_rd_q;
    logic [PW-1:0]   payload_q;
    logic            fwd1_valid, fwd2_valid;
    logic [XLEN-1:0] fwd1_val, fwd2_val;
    logic [XCNT-1:0] busy;

    logic            src1_live, src2_live, dst_live;
    logic [XCNT-1:0] wb_mask, set_mask, busy_eff;
    logic            hazard, issue;

    assign src1_live = use_rs1_q && (rs1_q != '0);
    assign src2_live = use_rs2_q && (rs2_q != '0);
    assign dst_live  = writes_rd_q && (rd_q != '0);

    assign wb_mask  = WB_VALID ? (ONE_HOT0 << WB_IDX) : '0;
    assign set_mask = (state == S_READ && dst_live) ? (ONE_HOT0 << rd_q) : '0;

    // A register being written back this cycle no longer blocks issue.
    assign busy_eff = busy & ~wb_mask;

    assign hazard = (src1_live && busy_eff[rs1_q]) ||
                    (src2_live && busy_eff[rs2_q]) ||
                    (dst_live  && busy_eff[rd_q]);

    assign issue = (state == S_STALL) && !hazard;

    assign ID_READY = (state == S_IDLE);
    assign RCH1_IDX = rs1_q;
    assign RCH2_IDX = rs2_q;
    assign RCH1_REQ = RSTN && issue && src1_live;
    assign RCH2_REQ = RSTN && issue && src2_live;
    assign SB_BUSY  = busy;

    // Scoreboard: clears from writeback, set from READ; set wins on collision.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            busy <= '0;
        end else begin
            busy <= ((busy & ~wb_mask) | set_mask) & ~ONE_HOT0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state        <= S_IDLE;
            rs1_q        <= '0;
            rs2_q        <= '0;
            rd_q         <= '0;
            use_rs1_q    <= 1'b0;
            use_rs2_q    <= 1'b0;
            writes_rd_q  <= 1'b0;
            payload_q    <= '0;
            fwd1_valid   <= 1'b0;
            fwd2_valid   <= 1'b0;
            fwd1_val     <= '0;
            fwd2_val     <= '0;
            EX_VALID     <= 1'b0;
            EX_OP1       <= '0;
            EX_OP2       <= '0;
            EX_RD        <= '0;
            EX_WRITES_RD <= 1'b0;
            EX_PAYLOAD   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ID_VALID) begin
                        rs1_q       <= ID_RS1;
                        rs2_q       <= ID_RS2;
                        rd_q        <= ID_RD;
                        use_rs1_q   <= ID_USE_RS1;
                        use_rs2_q   <= ID_USE_RS2;
                        writes_rd_q <= ID_WRITES_RD;
                        payload_q   <= ID_PAYLOAD;
                        fwd1_valid  <= 1'b0;
                        fwd2_valid  <= 1'b0;
                        state       <= S_STALL;
                    end
                end
                S_STALL: begin
                    // The read returns pre-write contents, so a writeback in the
                    // issue cycle must be captured here instead.
                    if (issue) begin
                        if (src1_live && WB_VALID && WB_IDX == rs1_q) begin
                            fwd1_valid <= 1'b1;
                            fwd1_val   <= WB_VAL;
                        end
                        if (src2_live && WB_VALID && WB_IDX == rs2_q) begin
                            fwd2_valid <= 1'b1;
                            fwd2_val   <= WB_VAL;
                        end
                        state <= S_READ;
                    end
                end
                S_READ: begin
                    EX_OP1       <= !src1_live ? '0 : (fwd1_valid ? fwd1_val : RCH1_VAL);
                    EX_OP2       <= !src2_live ? '0 : (fwd2_valid ? fwd2_val : RCH2_VAL);
                    EX_RD        <= rd_q;
                    EX_WRITES_RD <= writes_rd_q;
                    EX_PAYLOAD   <= payload_q;
                    EX_VALID     <= 1'b1;
                    state        <= S_HOLD;
                end
                default: begin
                    if (EX_READY) begin
                        EX_VALID <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Issue stage between decode and execute; acts as the requester side of the register file read channels.
- Accepts one decoded instruction at a time and stalls on RAW/WAW hazards using a per-register scoreboard.
- Issues reads on two read channels, forwards a same-cycle writeback value, and presents operands to execute under a valid/ready handshake.

Parameters:
XLEN, 32, register / operand width
XCNT, 32, number of architectural registers; AW = $clog2(XCNT) is derived, not overridable
PW, 32, width of the opaque decode payload passed through to execute

Ports:
CLK  in  1  clock
RSTN  in  1  reset, synchronous, active-low
ID_VALID  in  1  decode has an instruction
ID_READY  out  1  stage can accept an instruction
ID_RS1, ID_RS2, ID_RD  in  AW  source and destination indices
ID_USE_RS1, ID_USE_RS2  in  1  source is read
ID_WRITES_RD  in  1  instruction writes rd
ID_PAYLOAD  in  PW  opaque control bits
RCH1_IDX, RCH2_IDX  out  AW  register file read index
RCH1_REQ, RCH2_REQ  out  1  read request strobe
RCH1_VAL, RCH2_VAL  in  XLEN  read data, valid the cycle after REQ
WB_VALID  in  1  writeback this cycle
WB_IDX  in  AW  writeback destination
WB_VAL  in  XLEN  writeback data
EX_VALID  out  1  operands valid to execute
EX_READY  in  1  execute accepts
EX_OP1, EX_OP2  out  XLEN  operands
EX_RD  out  AW  destination index
EX_WRITES_RD  out  1  destination write flag
EX_PAYLOAD  out  PW  payload
SB_BUSY  out  XCNT  scoreboard bits, for debug and verification

Behaviour:
- Register file contract: RCHn_VAL at cycle t+1 returns contents as of cycle t, before any write committed at cycle t.
- Reset (RSTN=0 at a rising edge): state = IDLE, SB_BUSY = 0, EX_VALID = 0, all EX_* data = 0, RCHn_REQ = 0, internal latches cleared. Reset mid-operation discards the in-flight instruction; no request is held.
- States: IDLE, STALL, READ, HOLD.
- IDLE: ID_READY = 1; in every other state ID_READY = 0. On ID_VALID && ID_READY, latch all ID_* fields and go to STALL.
- STALL: hazard = (use_rs1 && rs1 != 0 && busy[rs1]) || (use_rs2 && rs2 != 0 && busy[rs2]) || (writes_rd && rd != 0 && busy[rd]).
  - busy[i] is treated as clear in the hazard check if WB_VALID && WB_IDX == i this cycle.
  - If hazard: remain in STALL with no REQ.
  - Otherwise: assert RCHn_REQ (combinationally, this cycle only) for each used, nonzero source, with RCHn_IDX = rsn, and go to READ.
  - If WB_VALID && WB_IDX == rsn (rsn != 0) in the issue cycle, latch WB_VAL as the forwarded value for that operand.
- READ: EX_OPn <= forwarded value if latched, else RCHn_VAL; 0 if the source is unused or rsn == 0.
  - Latch EX_RD, EX_WRITES_RD and EX_PAYLOAD; EX_VALID <= 1.
  - If writes_rd && rd != 0, set busy[rd].
  - Go to HOLD.
- HOLD: EX_* outputs stable while EX_VALID && !EX_READY. On EX_READY: EX_VALID <= 0, go to IDLE.
- Minimum latency: handshake at cycle 0, REQ at cycle 1, data captured at the end of cycle 2, EX_VALID = 1 from cycle 3. Throughput is at most one instruction per 4 cycles.
- Scoreboard:
  - WB_VALID clears busy[WB_IDX] every cycle, in any state except reset.
  - A set and a clear of the same index in the same cycle: set wins.
  - busy[0] is never set.
  - A clear of a non-busy index is a no-op.
- RCHn_IDX holds the latched rsn whenever REQ is low (value don't-care); REQ is never asserted outside STALL.
- A WB to a non-busy register during READ is a protocol violation; the block ignores it.

Test Plan:
- Reset: hold RSTN=0 for 2 cycles with ID_VALID=1 -> ID_READY=1, EX_VALID=0, SB_BUSY=0, no REQ.
- Basic read: regfile x5=0x1111, x6=0x2222; issue rs1=5, rs2=6, rd=7, writes_rd=1, EX_READY=1 -> REQ on both channels at cycle 1, EX_OP1=0x1111, EX_OP2=0x2222 at cycle 3, SB_BUSY[7]=1.
- x0 / unused: rs1=0, use_rs2=0 -> no REQ on either channel; EX_OP1=0, EX_OP2=0.
- RAW stall and forward: busy[7]=1; issue rs1=7 -> stays in STALL with no REQ; WB_VALID=1, WB_IDX=7, WB_VAL=0xABCD while regfile returns the stale 0x0 -> EX_OP1=0xABCD, busy[7]=0.
- Backpressure: EX_READY=0 for 5 cycles -> EX_VALID and EX_* stable, ID_READY=0; EX_READY=1 -> next cycle EX_VALID=0, ID_READY=1.
- Same-cycle set and clear: instruction with rd=3 reaches READ while WB_VALID=1, WB_IDX=3 -> busy[3]=1 afterwards. Reset asserted in HOLD -> EX_VALID=0 and SB_BUSY=0 the next cycle.
